// File: rtl/traffic_phase_ctrl.sv
// Four-way intersection phase controller: demand-driven round-robin greens, fixed yellow.
// Optional all-red clearance between yellow and the next green when ALL_RED_EN is defined.
module traffic_phase_ctrl #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       n_car,
    input  logic       s_car,
    input  logic       e_car,
    input  logic       w_car,
    input  logic       n_carL,
    input  logic       s_carL,
    input  logic       e_carL,
    input  logic       w_carL,
    output logic [4:0] state1,
    output logic [1:0] n_light,
    output logic [1:0] s_light,
    output logic [1:0] e_light,
    output logic [1:0] w_light,
    output logic [1:0] n_left,
    output logic [1:0] s_left,
    output logic [1:0] e_left,
    output logic [1:0] w_left,
    output logic       phase_change
);

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1
`ifdef ALL_RED_EN
        , ALLRED = 2'd2
`endif
    } state_t;

    localparam logic [7:0] GREEN_LOAD  = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] YELLOW_LOAD = 8'(YELLOW_TICKS - 1);
`ifdef ALL_RED_EN
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_TICKS - 1);
`endif

    state_t      state, state_n;
    logic [2:0]  cur, cur_n, nxt, nxt_n, probe, found_idx;
    logic [7:0]  tmr, tmr_n;
    logic        found;
    logic [7:0]  car_vec;
    logic [4:0]  code_n;
    logic [15:0] lamps_n, lamp_q;

    // Lane order {n, s, e, w straight, n, s, e, w left}; a phase's demand lanes equal its served lanes.
    function automatic logic [7:0] serve_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    serve_mask = 8'b1100_0000;
            3'd1:    serve_mask = 8'b0011_0000;
            3'd2:    serve_mask = 8'b1000_1000;
            3'd3:    serve_mask = 8'b0100_0100;
            3'd4:    serve_mask = 8'b0001_0001;
            3'd5:    serve_mask = 8'b0010_0010;
            3'd6:    serve_mask = 8'b0000_1100;
            default: serve_mask = 8'b0000_0011;
        endcase
    endfunction

    function automatic logic [4:0] green_code(input logic [2:0] idx);
        case (idx)
            3'd0:    green_code = 5'b00000;
            3'd1:    green_code = 5'b00001;
            default: green_code = {1'b0, idx, 1'b0};
        endcase
    endfunction

    function automatic logic [4:0] yellow_code(input logic [2:0] idx);
        case (idx)
            3'd0:    yellow_code = 5'b00010;
            3'd1:    yellow_code = 5'b00011;
            default: yellow_code = green_code(idx) + 5'd1;
        endcase
    endfunction

    function automatic logic [15:0] lamps(input logic [7:0] served, input logic [1:0] colour);
        lamps = '1;
        for (int i = 0; i < 8; i++) begin
            if (served[i]) lamps[2*i +: 2] = colour;
        end
    endfunction

    assign car_vec = {n_car, s_car, e_car, w_car, n_carL, s_carL, e_carL, w_carL};

    // Nearest demanded phase after cur; descending scan so the smallest offset wins.
    always_comb begin
        found     = 1'b0;
        found_idx = cur;
        probe     = cur;
        for (int k = 7; k >= 1; k--) begin
            probe = cur + 3'(k);
            if (|(car_vec & serve_mask(probe))) begin
                found     = 1'b1;
                found_idx = probe;
            end
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        nxt_n   = nxt;
        tmr_n   = tmr;
        if (rst) begin
            state_n = GREEN;
            cur_n   = 3'd0;
            tmr_n   = GREEN_LOAD;
        end else begin
            case (state)
                GREEN: begin
                    if (tmr != 8'd0) begin
                        tmr_n = tmr - 8'd1;
                    end else if (found) begin
                        nxt_n   = found_idx;
                        state_n = YELLOW;
                        tmr_n   = YELLOW_LOAD;
                    end
                end
                YELLOW: begin
                    if (tmr != 8'd0) begin
                        tmr_n = tmr - 8'd1;
                    end else begin
`ifdef ALL_RED_EN
                        state_n = ALLRED;
                        tmr_n   = ALLRED_LOAD;
`else
                        state_n = GREEN;
                        cur_n   = nxt;
                        tmr_n   = GREEN_LOAD;
`endif
                    end
                end
`ifdef ALL_RED_EN
                ALLRED: begin
                    if (tmr != 8'd0) begin
                        tmr_n = tmr - 8'd1;
                    end else begin
                        state_n = GREEN;
                        cur_n   = nxt;
                        tmr_n   = GREEN_LOAD;
                    end
                end
`endif
                default: begin
                    state_n = GREEN;
                    cur_n   = 3'd0;
                    tmr_n   = GREEN_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        code_n  = 5'b00000;
        lamps_n = '1;
        case (state_n)
            GREEN: begin
                code_n  = green_code(cur_n);
                lamps_n = lamps(serve_mask(cur_n), 2'b01);
            end
            YELLOW: begin
                code_n  = yellow_code(cur_n);
                lamps_n = lamps(serve_mask(cur_n), 2'b10);
            end
`ifdef ALL_RED_EN
            ALLRED: begin
                code_n  = 5'b10000;
                lamps_n = '1;
            end
`endif
            default: begin
                code_n  = 5'b00000;
                lamps_n = '1;
            end
        endcase
    end

    // Outputs are registered from next-state values so colours and state1 move on the same edge.
    always_ff @(posedge CLK) begin
        state        <= state_n;
        cur          <= cur_n;
        nxt          <= nxt_n;
        tmr          <= tmr_n;
        state1       <= code_n;
        lamp_q       <= lamps_n;
        phase_change <= !rst && (code_n != state1);
    end

    assign {n_light, s_light, e_light, w_light, n_left, s_left, e_left, w_left} = lamp_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: vector table, directed corner sequences and
// randomized demand against a cycle-counting reference model. Honours ALL_RED_EN.
module tb_traffic_phase_ctrl;

    localparam int G_T = 4;
    localparam int Y_T = 2;
    localparam int A_T = 2;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       n_car = 0, s_car = 0, e_car = 0, w_car = 0;
    logic       n_carL = 0, s_carL = 0, e_carL = 0, w_carL = 0;
    logic [4:0] state1;
    logic [1:0] n_light, s_light, e_light, w_light, n_left, s_left, e_left, w_left;
    logic       phase_change;

    traffic_phase_ctrl #(
        .GREEN_TICKS (G_T),
        .YELLOW_TICKS(Y_T),
        .ALLRED_TICKS(A_T)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .n_car       (n_car),
        .s_car       (s_car),
        .e_car       (e_car),
        .w_car       (w_car),
        .n_carL      (n_carL),
        .s_carL      (s_carL),
        .e_carL      (e_carL),
        .w_carL      (w_carL),
        .state1      (state1),
        .n_light     (n_light),
        .s_light     (s_light),
        .e_light     (e_light),
        .w_light     (w_light),
        .n_left      (n_left),
        .s_left      (s_left),
        .e_left      (e_left),
        .w_left      (w_left),
        .phase_change(phase_change)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Phase tables: green code, and served/demand lanes in order {nS,sS,eS,wS,nL,sL,eL,wL}.
    int         green_t[8] = '{0, 1, 4, 6, 8, 10, 12, 14};
    logic [7:0] lanes_t[8] = '{8'hC0, 8'h30, 8'h88, 8'h44, 8'h11, 8'h22, 8'h0C, 8'h03};

    // Model: mode 0 green, 1 yellow, 2 all-red; elapsed counts cycles already spent in the mode.
    int m_mode = 0, m_cur = 0, m_nxt = 0, m_el = 0, m_prev_code = 0;
    int e_code, e_lamps, e_pc;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lamp_word(input logic [7:0] served, input int colour);
        int w = 0;
        for (int i = 0; i < 8; i++) w |= (served[i] ? colour : 3) << (2 * i);
        return w;
    endfunction

    task automatic modelStep(input logic r, input logic [7:0] cars);
        if (r) begin
            m_mode = 0; m_cur = 0; m_el = 0;
        end else if (m_mode == 0) begin
            if (m_el >= G_T - 1) begin
                for (int k = 1; k < 8; k++) begin
                    if ((cars & lanes_t[(m_cur + k) % 8]) != 0) begin
                        m_nxt = (m_cur + k) % 8; m_mode = 1; m_el = 0;
                        break;
                    end
                end
            end else m_el++;
        end else if (m_mode == 1) begin
            if (m_el == Y_T - 1) begin
`ifdef ALL_RED_EN
                m_mode = 2; m_el = 0;
`else
                m_mode = 0; m_cur = m_nxt; m_el = 0;
`endif
            end else m_el++;
        end else begin
            if (m_el == A_T - 1) begin
                m_mode = 0; m_cur = m_nxt; m_el = 0;
            end else m_el++;
        end
        case (m_mode)
            0: begin e_code = green_t[m_cur]; e_lamps = lamp_word(lanes_t[m_cur], 1); end
            1: begin
                e_code  = (m_cur == 0) ? 2 : (m_cur == 1) ? 3 : green_t[m_cur] + 1;
                e_lamps = lamp_word(lanes_t[m_cur], 2);
            end
            default: begin e_code = 16; e_lamps = 16'hFFFF; end
        endcase
        e_pc = (!r && e_code != m_prev_code) ? 1 : 0;
        m_prev_code = e_code;
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] cars);
        rst = r;
        {n_car, s_car, e_car, w_car, n_carL, s_carL, e_carL, w_carL} = cars;
        @(posedge CLK);
        modelStep(r, cars);
        #1;
        checkOutput("state1", int'(state1), e_code);
        checkOutput("lights", int'({n_light, s_light, e_light, w_light, n_left, s_left, e_left, w_left}), e_lamps);
        checkOutput("phase_change", int'(phase_change), e_pc);
    endtask

    task automatic waitForCode(input string name, input logic [7:0] cars, input logic [4:0] code);
        bit hit = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            applyStimulus(1'b0, cars);
            hit = (state1 == code);
        end
        checkOutput(name, int'(hit), 1);
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] cars;
        logic [4:0] exp_state1;
        logic       exp_pc;
        logic [1:0] exp_e_light;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int ticks;
        logic [7:0] cars;

        vecs[0] = '{1'b1, 8'h00, 5'b00000, 1'b0, 2'b11};
        vecs[1] = '{1'b1, 8'h00, 5'b00000, 1'b0, 2'b11};
        vecs[2] = '{1'b0, 8'h20, 5'b00000, 1'b0, 2'b11};
        vecs[3] = '{1'b0, 8'h20, 5'b00000, 1'b0, 2'b11};
        vecs[4] = '{1'b0, 8'h20, 5'b00000, 1'b0, 2'b11};
        vecs[5] = '{1'b0, 8'h20, 5'b00010, 1'b1, 2'b11};
        vecs[6] = '{1'b0, 8'h20, 5'b00010, 1'b0, 2'b11};
`ifdef ALL_RED_EN
        vecs[7] = '{1'b0, 8'h20, 5'b10000, 1'b1, 2'b11};
        vecs[8] = '{1'b0, 8'h20, 5'b10000, 1'b0, 2'b11};
        vecs[9] = '{1'b0, 8'h20, 5'b00001, 1'b1, 2'b01};
`else
        vecs[7] = '{1'b0, 8'h20, 5'b00001, 1'b1, 2'b01};
        vecs[8] = '{1'b0, 8'h20, 5'b00001, 1'b0, 2'b01};
        vecs[9] = '{1'b0, 8'h20, 5'b00001, 1'b0, 2'b01};
`endif

        $display("[TB] basic switch table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].cars);
            checkOutput($sformatf("vec%0d.state1", i), int'(state1), int'(vecs[i].exp_state1));
            checkOutput($sformatf("vec%0d.pc", i), int'(phase_change), int'(vecs[i].exp_pc));
            checkOutput($sformatf("vec%0d.e_light", i), int'(e_light), int'(vecs[i].exp_e_light));
        end

        $display("[TB] round-robin skip and demand drop in yellow");
        waitForCode("reach_E_W_yellow", 8'h04, 5'b00011);
        applyStimulus(1'b0, 8'h00);
        checkOutput("yellow_held", int'(state1), 5'b00011);
        waitForCode("reach_S_SL", 8'h00, 5'b00110);
        checkOutput("s_light_green", int'(s_light), 1);
        checkOutput("s_left_green", int'(s_left), 1);

        $display("[TB] reset mid-yellow");
        applyStimulus(1'b1, 8'h00);
        waitForCode("reach_N_S_yellow", 8'h20, 5'b00010);
        applyStimulus(1'b1, 8'h20);
        checkOutput("rst_yellow.state1", int'(state1), 0);
        checkOutput("rst_yellow.n_light", int'(n_light), 1);
        checkOutput("rst_yellow.pc", int'(phase_change), 0);
        ticks = 0;
        for (int i = 0; i < 12 && state1 != 5'b00010; i++) begin
            applyStimulus(1'b0, 8'h20);
            ticks++;
        end
        checkOutput("green_after_rst_ticks", ticks, 4);

        $display("[TB] no demand");
        applyStimulus(1'b1, 8'h00);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("idle_hold", int'({state1, phase_change}), 0);
        end

        $display("[TB] randomized demand");
        for (int i = 0; i < 3000; i++) begin
            cars = '0;
            for (int b = 0; b < 8; b++) cars[b] = ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 199) == 0, cars);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
